// File: rtl/icache.sv
// rtl/icache.sv - direct-mapped read-only instruction cache, single-word fills
// Optional fill forwarding enabled by defining ICACHE_FWD_EN.
module icache #(
  parameter int SETS = 16
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  output logic        ihit,
  output logic [31:0] imemload,
  output logic        iREN,
  output logic [31:0] iaddr,
  input  logic        iwait,
  input  logic [31:0] iload
);
  localparam int IW = $clog2(SETS);
  localparam int TW = 30 - IW;

  typedef enum logic {IDLE = 1'b0, MISS = 1'b1} state_t;
  state_t state, next_state;

  logic [SETS-1:0] valid;
  logic [TW-1:0]   tag_arr  [SETS];
  logic [31:0]     data_arr [SETS];
  logic [31:0]     miss_addr;

  logic [IW-1:0] req_idx;
  logic [IW-1:0] fill_idx;
  logic [TW-1:0] req_tag;
  logic [31:0]   req_word;
  logic          lookup_hit;
  logic          start_miss;
  logic          fill_done;
  logic          unused_offset;

  assign req_idx       = imemaddr[IW+1:2];
  assign req_tag       = imemaddr[31:IW+2];
  assign req_word      = {imemaddr[31:2], 2'b00};
  assign fill_idx      = miss_addr[IW+1:2];
  assign unused_offset = ^imemaddr[1:0];

  assign lookup_hit = imemREN & valid[req_idx] & (tag_arr[req_idx] == req_tag);
  assign start_miss = (state == IDLE) & imemREN & ~lookup_hit;
  assign fill_done  = (state == MISS) & ~iwait;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start_miss) next_state = MISS;
      MISS:    if (fill_done)  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    ihit     = 1'b0;
    imemload = 32'h0;
    iREN     = 1'b0;
    iaddr    = 32'h0;
    case (state)
      IDLE: begin
        if (lookup_hit) begin
          ihit     = 1'b1;
          imemload = data_arr[req_idx];
        end
      end
      MISS: begin
        iREN  = 1'b1;
        iaddr = miss_addr;
`ifdef ICACHE_FWD_EN
        // Returning word matches the live fetch: hand it straight to the datapath.
        if (fill_done && imemREN && (req_word == miss_addr)) begin
          ihit     = 1'b1;
          imemload = iload;
        end
`endif
      end
      default: begin
        ihit = 1'b0;
      end
    endcase
  end

  // Valid bits reset asynchronously so a reset mid-fill leaves every frame empty.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      valid     <= '0;
      miss_addr <= 32'h0;
    end else begin
      if (start_miss) miss_addr <= req_word;
      if (fill_done)  valid[fill_idx] <= 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (fill_done) begin
      tag_arr[fill_idx]  <= miss_addr[31:IW+2];
      data_arr[fill_idx] <= iload;
    end
  end

endmodule
